// File: rtl/cam_ctrl_pkg.sv
// cam_ctrl shared types: opcodes, FSM states, depth helper.
// Imported by cam_ctrl and cam_free_find.
package cam_ctrl_pkg;

  typedef enum logic [1:0] {
    OP_LOOKUP = 2'd0,
    OP_INSERT = 2'd1,
    OP_DELETE = 2'd2,
    OP_RSVD   = 2'd3
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SEARCH = 3'd1,
    ST_WAIT   = 3'd2,
    ST_DECIDE = 3'd3,
    ST_WRITE  = 3'd4,
    ST_RESP   = 3'd5
  } state_e;

  localparam logic [31:0] STAT_MAX = 32'hFFFF_FFFF;

  function automatic int unsigned depth_f(
    input int unsigned aw
  );
    return 32'd1 << aw;
  endfunction

endpackage

// File: rtl/cam_free_find.sv
// Lowest-zero finder over the entry valid bitmap.
// free_valid is low when every entry is in use.
module cam_free_find
  import cam_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 5
) (
  input  logic [depth_f(ADDR_WIDTH)-1:0] valid_i,
  output logic                           free_valid,
  output logic [ADDR_WIDTH-1:0]          free_index
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);

  // Scan high to low so the lowest free index wins.
  always_comb begin
    free_valid = 1'b0;
    free_index = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!valid_i[i]) begin
        free_valid = 1'b1;
        free_index = ADDR_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/cam_ctrl.sv
// CAM request sequencer: lookup/insert/delete with victim choice.
// Optional hit/miss/evict counters under macro CAM_CTRL_STATS_EN.
module cam_ctrl
  import cam_ctrl_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int SEARCH_LAT = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [1:0]            req_op_i,
  input  logic [WIDTH-1:0]      req_key_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic                  rsp_hit_o,
  output logic [ADDR_WIDTH-1:0] rsp_index_o,
  output logic                  rsp_evict_o,
  output logic                  rsp_err_o,
  output logic                  cam_search_enable_o,
  output logic [WIDTH-1:0]      cam_search_data_o,
  input  logic                  cam_search_valid_i,
  input  logic [ADDR_WIDTH-1:0] cam_search_index_i,
  output logic                  cam_write_enable_o,
  output logic [ADDR_WIDTH-1:0] cam_write_index_o,
  output logic [WIDTH-1:0]      cam_write_data_o
`ifdef CAM_CTRL_STATS_EN
  ,
  input  logic                  stat_clr_i,
  output logic [31:0]           stat_hits_o,
  output logic [31:0]           stat_misses_o,
  output logic [31:0]           stat_evicts_o
`endif
);

  localparam int DEPTH = depth_f(ADDR_WIDTH);
  localparam logic [1:0] WAIT_INIT =
    (SEARCH_LAT > 1) ? 2'(SEARCH_LAT - 1) : 2'd0;

  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [WIDTH-1:0]        key_q, key_d;
  logic [1:0]              wcnt_q, wcnt_d;
  logic                    raw_q, raw_d;
  logic [ADDR_WIDTH-1:0]   idx_q, idx_d;
  logic [DEPTH-1:0]        valid_q, valid_d;
  logic [ADDR_WIDTH-1:0]   rr_q, rr_d;
  logic [ADDR_WIDTH-1:0]   tgt_q, tgt_d;
  logic                    hit_q, hit_d;
  logic [ADDR_WIDTH-1:0]   ridx_q, ridx_d;
  logic                    evict_q, evict_d;
  logic                    err_q, err_d;

  logic                    hit_now;
  logic [ADDR_WIDTH-1:0]   ins_tgt;
  logic                    free_valid;
  logic [ADDR_WIDTH-1:0]   free_index;

  cam_free_find #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_free (
    .valid_i    (valid_q),
    .free_valid (free_valid),
    .free_index (free_index)
  );

  // A match only counts if the entry is still marked valid.
  assign hit_now = raw_q & valid_q[idx_q];

  assign rsp_valid_o = (state_q == ST_RESP);
  assign rsp_hit_o   = hit_q;
  assign rsp_index_o = ridx_q;
  assign rsp_evict_o = evict_q;
  assign rsp_err_o   = err_q;

  // Next-state, bookkeeping and CAM port drive.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    key_d   = key_q;
    wcnt_d  = wcnt_q;
    raw_d   = raw_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    rr_d    = rr_q;
    tgt_d   = tgt_q;
    hit_d   = hit_q;
    ridx_d  = ridx_q;
    evict_d = evict_q;
    err_d   = err_q;
    ins_tgt = '0;
    req_ready_o         = 1'b0;
    cam_search_enable_o = 1'b0;
    cam_search_data_o   = '0;
    cam_write_enable_o  = 1'b0;
    cam_write_index_o   = '0;
    cam_write_data_o    = '0;
    unique case (state_q)
      ST_IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          op_d    = op_e'(req_op_i);
          key_d   = req_key_i;
          hit_d   = 1'b0;
          ridx_d  = '0;
          evict_d = 1'b0;
          err_d   = 1'b0;
          if (op_e'(req_op_i) == OP_RSVD) begin
            err_d   = 1'b1;
            state_d = ST_RESP;
          end else begin
            state_d = ST_SEARCH;
          end
        end
      end
      ST_SEARCH: begin
        cam_search_enable_o = 1'b1;
        cam_search_data_o   = key_q;
        if (SEARCH_LAT == 0) begin
          raw_d   = cam_search_valid_i;
          idx_d   = cam_search_index_i;
          state_d = ST_DECIDE;
        end else begin
          wcnt_d  = WAIT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wcnt_q == 2'd0) begin
          raw_d   = cam_search_valid_i;
          idx_d   = cam_search_index_i;
          state_d = ST_DECIDE;
        end else begin
          wcnt_d = wcnt_q - 2'd1;
        end
      end
      ST_DECIDE: begin
        state_d = ST_RESP;
        unique case (op_q)
          OP_LOOKUP: begin
            hit_d  = hit_now;
            ridx_d = hit_now ? idx_q : '0;
          end
          OP_DELETE: begin
            hit_d  = hit_now;
            ridx_d = hit_now ? idx_q : '0;
            if (hit_now) valid_d[idx_q] = 1'b0;
          end
          OP_INSERT: begin
            if (raw_q) begin
              // Reuse the matching slot; stale ones get rewritten.
              ins_tgt = idx_q;
              hit_d   = hit_now;
              if (!hit_now) state_d = ST_WRITE;
            end else begin
              if (free_valid) begin
                ins_tgt = free_index;
              end else begin
                ins_tgt = rr_q;
                evict_d = 1'b1;
                rr_d    = rr_q + 1'b1;
              end
              state_d = ST_WRITE;
            end
            tgt_d            = ins_tgt;
            ridx_d           = ins_tgt;
            valid_d[ins_tgt] = 1'b1;
          end
          default: ;
        endcase
      end
      ST_WRITE: begin
        cam_write_enable_o = 1'b1;
        cam_write_index_o  = tgt_q;
        cam_write_data_o   = key_q;
        state_d            = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers, synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      op_q    <= OP_LOOKUP;
      key_q   <= '0;
      wcnt_q  <= '0;
      raw_q   <= 1'b0;
      idx_q   <= '0;
      valid_q <= '0;
      rr_q    <= '0;
      tgt_q   <= '0;
      hit_q   <= 1'b0;
      ridx_q  <= '0;
      evict_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      key_q   <= key_d;
      wcnt_q  <= wcnt_d;
      raw_q   <= raw_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      rr_q    <= rr_d;
      tgt_q   <= tgt_d;
      hit_q   <= hit_d;
      ridx_q  <= ridx_d;
      evict_q <= evict_d;
      err_q   <= err_d;
    end
  end

`ifdef CAM_CTRL_STATS_EN
  logic [31:0] hits_q, hits_d;
  logic [31:0] miss_q, miss_d;
  logic [31:0] evic_q, evic_d;
  logic        is_decide;

  assign is_decide     = (state_q == ST_DECIDE);
  assign stat_hits_o   = hits_q;
  assign stat_misses_o = miss_q;
  assign stat_evicts_o = evic_q;

  // Saturating counters; clear takes priority over counting.
  always_comb begin
    hits_d = hits_q;
    miss_d = miss_q;
    evic_d = evic_q;
    if (stat_clr_i) begin
      hits_d = '0;
      miss_d = '0;
      evic_d = '0;
    end else if (is_decide) begin
      if (op_q == OP_LOOKUP) begin
        if (hit_now && hits_q != STAT_MAX)
          hits_d = hits_q + 32'd1;
        if (!hit_now && miss_q != STAT_MAX)
          miss_d = miss_q + 32'd1;
      end
      if (op_q == OP_INSERT && !raw_q &&
          !free_valid && evic_q != STAT_MAX)
        evic_d = evic_q + 32'd1;
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      hits_q <= '0;
      miss_q <= '0;
      evic_q <= '0;
    end else begin
      hits_q <= hits_d;
      miss_q <= miss_d;
      evic_q <= evic_d;
    end
  end
`endif

endmodule

// File: doc/cam_ctrl.md
Name: cam_ctrl

Overview:
- Request sequencer in front of the cam block. Accepts one LOOKUP / INSERT / DELETE command at a time over a valid/ready channel and drives the CAM search and write ports.
- Tracks per-entry valid bits and chooses the victim entry on insert, so the CAM never holds duplicate keys.
- Returns hit, index and eviction status over a valid/ready response channel.

Parameters:
- WIDTH, 32, key width; matches cam WIDTH.
- ADDR_WIDTH, 5, index width; DEPTH = 2**ADDR_WIDTH entries.
- SEARCH_LAT, 1, cycles from cam_search_enable_o to a valid cam_search_valid_i/cam_search_index_i (range 0..3).

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_i  in  1  synchronous active-low reset.
- req_valid_i  in  1  command valid.
- req_ready_o  out  1  controller can accept a command.
- req_op_i  in  2  0=LOOKUP, 1=INSERT, 2=DELETE, 3=reserved.
- req_key_i  in  WIDTH  key.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response accepted.
- rsp_hit_o  out  1  key was present and valid before the command.
- rsp_index_o  out  ADDR_WIDTH  entry index touched or found.
- rsp_evict_o  out  1  INSERT overwrote a valid entry.
- rsp_err_o  out  1  reserved opcode.
- cam_search_enable_o  out  1  CAM search strobe.
- cam_search_data_o  out  WIDTH  CAM search key.
- cam_search_valid_i  in  1  CAM match found.
- cam_search_index_i  in  ADDR_WIDTH  CAM priority-encoded match index.
- cam_write_enable_o  out  1  CAM write strobe.
- cam_write_index_o  out  ADDR_WIDTH  CAM write index.
- cam_write_data_o  out  WIDTH  CAM write data.

Behaviour:
- Reset (rst_i=0 at a clock edge):
  - FSM goes to IDLE; valid bitmap all 0; rr_ptr = 0.
  - Outputs: req_ready_o=1, rsp_valid_o=0, all cam_*_enable_o=0, data and index outputs 0.
  - Reset mid-command abandons the command and issues no CAM write.
- FSM states: IDLE, SEARCH, WAIT, DECIDE, WRITE, RESP.
- IDLE:
  - req_ready_o=1.
  - Handshake is req_valid_i & req_ready_o. On handshake, latch op and key, then go to SEARCH.
  - A reserved op goes straight to RESP with rsp_err_o=1 and all other response fields 0.
- SEARCH:
  - cam_search_enable_o=1 for exactly one cycle, with cam_search_data_o = latched key.
  - Next state is WAIT if SEARCH_LAT>0, else DECIDE.
  - With SEARCH_LAT=0, the CAM result is sampled in SEARCH itself.
- WAIT: count SEARCH_LAT-1 further cycles, then sample the CAM result and go to DECIDE.
- Result definitions:
  - raw = cam_search_valid_i.
  - hit = raw & valid[idx], where idx = cam_search_index_i.
- DECIDE:
  - LOOKUP: rsp_hit=hit, rsp_index = hit ? idx : 0. Go to RESP.
  - DELETE: if hit, clear valid[idx]; rsp_hit=hit, rsp_index=idx (0 on miss). Go to RESP. No CAM write; a stale key stays in the CAM but is masked.
  - INSERT, raw match (valid or stale):
    - Reuse idx, set valid[idx], rsp_hit=hit.
    - If the entry was stale, go to WRITE (rewrite same key); if valid, go straight to RESP.
  - INSERT, no raw match:
    - Target = lowest index with valid=0, if any.
    - Otherwise target = rr_ptr; rsp_evict=1; rr_ptr increments and wraps DEPTH-1 -> 0.
    - Set valid[target]; go to WRITE.
- WRITE: cam_write_enable_o=1 for one cycle, index=target, data=key; then RESP.
- RESP:
  - rsp_valid_o=1 and response fields are held stable until rsp_ready_i=1; then go to IDLE.
  - req_ready_o=0 in every state except IDLE, so no command overlap.
  - A new command can be accepted no earlier than the cycle after the response handshake.
- Latency, accept to rsp_valid_o (SEARCH_LAT=1):
  - LOOKUP, DELETE, and INSERT on a valid hit: 3 cycles.
  - INSERT with a write: 4 cycles.
- rsp_evict_o=0 for every op except a full-table INSERT miss.
- cam_write_* and cam_search_* enables are never asserted in the same cycle.

Optional Feature:
- Macro CAM_CTRL_STATS_EN.
- When defined:
  - Extra outputs stat_hits_o[31:0], stat_misses_o[31:0], stat_evicts_o[31:0].
  - hits/misses increment once per LOOKUP response; evicts increments per evicting INSERT.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
  - Extra input stat_clr_i clears all three counters synchronously; clear wins over an increment in the same cycle.
- When undefined: the ports and counters are absent; the rest of the behaviour is identical.

Decomposition:
- Package cam_ctrl_pkg:
  - op_e enum (OP_LOOKUP, OP_INSERT, OP_DELETE, OP_RSVD).
  - state_e enum.
  - localparam-style function for DEPTH.
- Sub-module cam_free_find: combinational lowest-zero finder over the DEPTH-bit valid bitmap. Outputs free_valid and free_index.

Test Plan:
- After reset, INSERT key 0xA5A5_0001: CAM mock misses -> write at index 0, rsp_hit=0, rsp_index=0, rsp_evict=0. Then LOOKUP of the same key -> hit=1, index=0.
- INSERT 0xA5A5_0001 again: mock returns valid match at 0 -> no cam_write_enable_o pulse, rsp_hit=1, rsp_index=0.
- DELETE at index 0, then LOOKUP: mock raw-matches 0 -> rsp_hit=0. Then INSERT the same key -> stale reuse: write at index 0, rsp_hit=0.
- Fill all 32 entries with distinct keys, then INSERT a 33rd key -> evict index 0, rsp_evict=1. A 34th new key -> evict index 1 (rr_ptr advanced).
- Hold rsp_ready_i=0 for 5 cycles: rsp fields stable and req_ready_o=0 throughout. Reserved op 3 -> rsp_err_o=1 with no CAM strobes.
- Assert rst_i=0 during WAIT of an INSERT: no CAM write, valid bitmap cleared. The next LOOKUP of that key misses. With SEARCH_LAT=0 and 3, latency is checked as 2/5 cycles for LOOKUP.
